// File: rtl/boundary_strip.sv
// rtl/boundary_strip.sv - strips zero-boundary padding from a raster stream, emitting interior pixels with x/y.
// Optional BOUNDARY_STRIP_PADCHECK_EN adds oPadErr/oPadErrCnt for non-zero data seen on pad beats.
module boundary_strip #(
  parameter int width      = 1920,
  parameter int height     = 1080,
  parameter int kernelSize = 7
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        newFrame,
  input  logic        iValid,
  input  logic [23:0] iData,
  output logic [23:0] oData,
  output logic        oValid,
  output logic [31:0] oX,
  output logic [31:0] oY,
  output logic        oDone,
  output logic        oFrameErr
`ifdef BOUNDARY_STRIP_PADCHECK_EN
  ,
  output logic        oPadErr,
  output logic [15:0] oPadErrCnt
`endif
);

  localparam int B  = (kernelSize - 1) / 2;
  localparam int PW = width + 2 * B;
  localparam int PH = height + 2 * B;
  localparam int CW = $clog2(PW + 1);
  localparam int RW = $clog2(PH + 1);

  localparam logic [CW-1:0] COL_LO   = CW'(B);
  localparam logic [CW-1:0] COL_HI   = CW'(width + B);
  localparam logic [CW-1:0] COL_END  = CW'(width + B - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(PW - 1);
  localparam logic [RW-1:0] ROW_LO   = RW'(B);
  localparam logic [RW-1:0] ROW_HI   = RW'(height + B);
  localparam logic [RW-1:0] ROW_END  = RW'(height + B - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(PH - 1);

  typedef enum logic [1:0] {IDLE, TOP, ROW, BOTTOM} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;
  logic          valid_q, valid_d;
  logic [23:0]   data_q, data_d;
  logic [31:0]   x_q, x_d;
  logic [31:0]   y_q, y_d;
  logic          done_q, done_d;
  logic          frame_err_q, frame_err_d;

  logic is_interior;
  logic beat_interior;
  logic last_beat;
  logic restart;

  // Region the stream is in once the beat at (c, r) is next to arrive.
  function automatic state_t pos_state(input logic [CW-1:0] c, input logic [RW-1:0] r);
    if (r < ROW_LO)
      return TOP;
    if (r > ROW_END || (r == ROW_END && c >= COL_HI))
      return BOTTOM;
    return ROW;
  endfunction

  // newFrame forces the current beat (if any) to be padded pixel (0,0).
  always_comb begin
    cur_col       = newFrame ? '0 : col_q;
    cur_row       = newFrame ? '0 : row_q;
    is_interior   = (cur_row >= ROW_LO) && (cur_row < ROW_HI) &&
                    (cur_col >= COL_LO) && (cur_col < COL_HI);
    beat_interior = iValid && is_interior;
    last_beat     = iValid && (cur_col == COL_LAST) && (cur_row == ROW_LAST);
    restart       = newFrame && (state_q != IDLE);
  end

  always_comb begin
    col_d = cur_col;
    row_d = cur_row;
    if (iValid) begin
      if (last_beat) begin
        col_d = '0;
        row_d = '0;
      end else if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      x_q         <= x_d;
      y_q         <= y_d;
      done_q      <= done_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (last_beat)
      state_d = IDLE;
    else if (iValid || restart)
      state_d = pos_state(col_d, row_d);
  end

  always_comb begin
    valid_d     = beat_interior;
    data_d      = data_q;
    x_d         = x_q;
    y_d         = y_q;
    done_d      = beat_interior && (cur_col == COL_END) && (cur_row == ROW_END);
    frame_err_d = frame_err_q | restart;
    if (beat_interior) begin
      data_d = iData;
      x_d    = 32'(cur_col - COL_LO);
      y_d    = 32'(cur_row - ROW_LO);
    end
  end

  assign oValid    = valid_q;
  assign oData     = data_q;
  assign oX        = x_q;
  assign oY        = y_q;
  assign oDone     = done_q;
  assign oFrameErr = frame_err_q;

`ifdef BOUNDARY_STRIP_PADCHECK_EN
  logic        pad_err_q, pad_err_d;
  logic [15:0] pad_cnt_q, pad_cnt_d;
  logic        pad_dirty;

  always_comb begin
    pad_dirty = iValid && !is_interior && (iData != 24'h0);
    pad_err_d = pad_err_q | pad_dirty;
    pad_cnt_d = pad_cnt_q;
    if (pad_dirty && pad_cnt_q != 16'hFFFF)
      pad_cnt_d = pad_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pad_err_q <= 1'b0;
      pad_cnt_q <= '0;
    end else begin
      pad_err_q <= pad_err_d;
      pad_cnt_q <= pad_cnt_d;
    end
  end

  assign oPadErr    = pad_err_q;
  assign oPadErrCnt = pad_cnt_q;
`endif

endmodule
